stage_ram_writer: RTL and testbench

//   Update engine for one 4-bit-stride trie stage RAM; the write-side counterpart of the per-stage lookup.

---
 rtl/stage_ram_writer_if.sv | 38 +++
 rtl/stage_ram_writer.sv | 129 ++++++++++++
 tb/tb_stage_ram_writer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/stage_ram_writer_if.sv
// rtl/stage_ram_writer_if.sv - update-request handshake between rule loader and stage RAM writer
//
// Signals (direction as seen by the writer, modport slave):
//   req_valid    in   request valid
//   req_ready    out  writer idle; request taken on valid & ready
//   req_op       in   0 = set nexthop, 1 = set child pointer
//   req_block    in   target block index (BLK_BITS)
//   req_prefix   in   prefix bits within the 4-bit stride, MSB-aligned
//   req_len      in   prefix length within the stride (nexthop only)
//   req_nexthop  in   nexthop value
//   req_child    in   child block pointer (DATA_WIDTH-9)
//   done         out  one-cycle completion pulse
//   err          out  qualified by done: request rejected, nothing written
interface stage_ram_writer_if #(
    parameter int BLK_BITS   = 4,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_op;
    logic [BLK_BITS-1:0]   req_block;
    logic [3:0]            req_prefix;
    logic [2:0]            req_len;
    logic [7:0]            req_nexthop;
    logic [DATA_WIDTH-10:0] req_child;
    logic                  done;
    logic                  err;

    modport master (
        output req_valid, req_op, req_block, req_prefix, req_len, req_nexthop, req_child,
        input  req_ready, done, err
    );

    modport slave (
        input  req_valid, req_op, req_block, req_prefix, req_len, req_nexthop, req_child,
        output req_ready, done, err
    );
endinterface

// File: rtl/stage_ram_writer.sv
// rtl/stage_ram_writer.sv - read-modify-write update engine for one 4-bit-stride trie stage RAM
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low
//   req          stage_ram_writer_if.slave: update request handshake plus done/err
//   ram_rd_addr  RAM read address {block, slot}; data returns one cycle later
//   ram_rd_data  RAM read data
//   ram_wr_en    RAM write strobe
//   ram_wr_addr  RAM write address {block, slot}
//   ram_wr_data  RAM write data: exist | nexthop[7:0] | child_ptr
module stage_ram_writer #(
    parameter int NUM_ENTRY  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int BLK_BITS   = $clog2(NUM_ENTRY)
) (
    input  logic                  clk,
    input  logic                  rst,
    stage_ram_writer_if.slave     req,
    output logic [BLK_BITS+3:0]   ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  ram_wr_en,
    output logic [BLK_BITS+3:0]   ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data
);
    localparam int CW = DATA_WIDTH - 9;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t              state;
    state_t              state_next;

    logic                op_q;
    logic [BLK_BITS-1:0] blk_q;
    logic [3:0]          base_q;
    logic [3:0]          last_q;
    logic [3:0]          idx_q;
    logic [7:0]          nh_q;
    logic [CW-1:0]       child_q;
    logic                err_q;

    logic                accept;
    logic                bad_len;
    logic [3:0]          span_mask;
    logic [3:0]          slot;
    logic [BLK_BITS+3:0] slot_addr;

    // Low (4-len) bits set: doubles as the alignment mask for the base slot
    // and as (slot count - 1) for a nexthop expansion.
    assign span_mask = 4'hF >> req.req_len;
    assign bad_len   = (req.req_op == 1'b0) && (req.req_len > 3'd4);
    assign accept    = (state == IDLE) && req.req_valid;
    // base is aligned to the span, so this 4-bit sum never wraps.
    assign slot      = base_q + idx_q;
    assign slot_addr = {blk_q, slot};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            op_q    <= 1'b0;
            blk_q   <= '0;
            base_q  <= '0;
            last_q  <= '0;
            idx_q   <= '0;
            nh_q    <= '0;
            child_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q    <= req.req_op;
                blk_q   <= req.req_block;
                nh_q    <= req.req_nexthop;
                child_q <= req.req_child;
                idx_q   <= '0;
                err_q   <= bad_len;
                if (req.req_op) begin
                    base_q <= req.req_prefix;
                    last_q <= '0;
                end else begin
                    base_q <= req.req_prefix & ~span_mask;
                    last_q <= span_mask;
                end
            end else if (state == WR && idx_q != last_q) begin
                idx_q <= idx_q + 4'd1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        req.req_ready = 1'b0;
        req.done      = 1'b0;
        req.err       = 1'b0;
        ram_rd_addr   = '0;
        ram_wr_en     = 1'b0;
        ram_wr_addr   = '0;
        ram_wr_data   = '0;
        case (state)
            IDLE: begin
                req.req_ready = 1'b1;
                if (req.req_valid) begin
                    state_next = bad_len ? DONE : RD;
                end
            end
            RD: begin
                ram_rd_addr = slot_addr;
                state_next  = WR;
            end
            WR: begin
                // Only the field being updated changes; the rest comes from the read.
                ram_wr_en   = 1'b1;
                ram_wr_addr = slot_addr;
                if (op_q) begin
                    ram_wr_data = {ram_rd_data[DATA_WIDTH-1:DATA_WIDTH-9], child_q};
                end else begin
                    ram_wr_data = {1'b1, nh_q, ram_rd_data[DATA_WIDTH-10:0]};
                end
                state_next = (idx_q == last_q) ? DONE : RD;
            end
            DONE: begin
                req.done   = 1'b1;
                req.err    = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_stage_ram_writer.sv
// tb/tb_stage_ram_writer.sv - self-checking bench for stage_ram_writer
module tb_stage_ram_writer;
    localparam int BB = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stage_ram_writer_if #(.BLK_BITS(BB), .DATA_WIDTH(DW)) rif ();

    logic [BB+3:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic          ram_wr_en;
    logic [BB+3:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;

    stage_ram_writer #(.NUM_ENTRY(16), .DATA_WIDTH(DW), .BLK_BITS(BB)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (rif),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data)
    );

    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];
    logic        pk_en = 1'b0;
    logic [7:0]  pk_a  = '0;
    logic [15:0] pk_d  = '0;
    int          cycle    = 0;
    int          wr_count = 0;
    logic [7:0]  last_wa  = '0;
    logic [15:0] last_wd  = '0;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Stage RAM: registered read, write on strobe; pk_* preloads contents.
    always @(posedge clk) begin
        cycle       <= cycle + 1;
        ram_rd_data <= mem[ram_rd_addr];
        if (pk_en) mem[pk_a] <= pk_d;
        if (ram_wr_en) begin
            mem[ram_wr_addr] <= ram_wr_data;
            wr_count         <= wr_count + 1;
            last_wa          <= ram_wr_addr;
            last_wd          <= ram_wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        pk_en = 1'b1; pk_a = a; pk_d = d; ref_mem[a] = d;
        @(posedge clk); #1;
        pk_en = 1'b0;
    endtask

    // Reference: apply one request to ref_mem; n = writes expected, e = reject.
    task automatic model(input logic op, input logic [3:0] blk, input logic [3:0] prefix,
                         input logic [2:0] len, input logic [7:0] nh, input logic [6:0] child,
                         output int n, output logic e);
        int a;
        int span;
        int base;
        e = 1'b0;
        if (!op && len > 4) begin
            n = 0; e = 1'b1;
        end else if (!op) begin
            span = 1 << (4 - int'(len));
            base = (int'(prefix) / span) * span;
            for (int i = 0; i < span; i++) begin
                a = int'(blk) * 16 + base + i;
                ref_mem[a] = {1'b1, nh, ref_mem[a][6:0]};
            end
            n = span;
        end else begin
            a = int'(blk) * 16 + int'(prefix);
            ref_mem[a] = {ref_mem[a][15:7], child};
            n = 1;
        end
    endtask

    task automatic check_block(input string tag, input logic [3:0] blk);
        for (int s = 0; s < 16; s++)
            chk(tag, 32'(mem[int'(blk) * 16 + s]), 32'(ref_mem[int'(blk) * 16 + s]));
    endtask

    task automatic do_req(input logic op, input logic [3:0] blk, input logic [3:0] prefix,
                          input logic [2:0] len, input logic [7:0] nh, input logic [6:0] child,
                          input logic noise);
        int n, t0, w0, k;
        logic e, got;
        model(op, blk, prefix, len, nh, child, n, e);
        @(negedge clk);
        k = 0;
        while (!rif.req_ready && k < 40) begin @(negedge clk); k++; end
        chk("ready_before_req", 32'(rif.req_ready), 32'd1);
        rif.req_op = op; rif.req_block = blk; rif.req_prefix = prefix;
        rif.req_len = len; rif.req_nexthop = nh; rif.req_child = child;
        rif.req_valid = 1'b1;
        w0 = wr_count;
        @(posedge clk);
        @(negedge clk);
        t0 = cycle;
        chk("ready_low_busy", 32'(rif.req_ready), 32'd0);
        if (noise) begin
            // Requests while busy must be dropped, not queued.
            rif.req_op = 1'($urandom); rif.req_block = 4'($urandom);
            rif.req_prefix = 4'($urandom); rif.req_len = 3'($urandom_range(0, 4));
            rif.req_nexthop = 8'($urandom); rif.req_child = 7'($urandom);
        end else begin
            rif.req_valid = 1'b0;
        end
        got = 1'b0;
        for (int j = 0; j < 60; j++) begin
            if (rif.done) begin got = 1'b1; break; end
            @(negedge clk);
        end
        rif.req_valid = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("done_time", 32'(cycle + 1 - t0), 32'(2 * n + 1));
        chk("err", 32'(rif.err), 32'(e));
        chk("write_count", 32'(wr_count - w0), 32'(n));
        @(negedge clk);
        chk("done_one_cycle", 32'(rif.done), 32'd0);
        chk("ready_after", 32'(rif.req_ready), 32'd1);
        check_block("mem_block", blk);
    endtask

    initial begin
        int n, w0, k;
        logic e;
        rif.req_valid = 1'b0; rif.req_op = 1'b0; rif.req_block = '0; rif.req_prefix = '0;
        rif.req_len = '0; rif.req_nexthop = '0; rif.req_child = '0;

        for (int a = 0; a < 256; a++) poke(8'(a), 16'($urandom));
        for (int s = 0; s < 16; s++) poke(8'(16 + s), 16'h0000);
        poke(8'h3A, 16'h01C5);
        poke(8'h0F, 16'hFF80);

        @(negedge clk);
        chk("rst_ready", 32'(rif.req_ready), 32'd1);
        chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_done", 32'(rif.done), 32'd0);
        chk("rst_err", 32'(rif.err), 32'd0);
        chk("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
        chk("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
        chk("rst_wr_data", 32'(ram_wr_data), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(rif.req_ready), 32'd1);
            chk("idle_wr_en", 32'(ram_wr_en), 32'd0);
            chk("idle_done", 32'(rif.done), 32'd0);
        end

        // Single-slot nexthop; child bits 7'h45 survive.
        do_req(1'b0, 4'd3, 4'b1010, 3'd4, 8'h2A, 7'h00, 1'b0);
        chk("nh_single_addr", 32'(last_wa), 32'h3A);
        chk("nh_single_data", 32'(last_wd), 32'h9545);

        // Four-slot expansion over a zero block, with junk requests while busy.
        do_req(1'b0, 4'd1, 4'b0110, 3'd2, 8'h07, 7'h00, 1'b1);
        chk("nh_span_data", 32'(mem[16 + 5]), 32'h8380);
        chk("nh_span_untouched", 32'(mem[16 + 8]), 32'h0000);

        // Child pointer keeps exist/nexthop.
        do_req(1'b1, 4'd0, 4'hF, 3'd0, 8'h00, 7'h15, 1'b0);
        chk("child_data", 32'(last_wd), 32'hFF95);

        // Illegal length: rejected without RAM access.
        do_req(1'b0, 4'd2, 4'h3, 3'd5, 8'h11, 7'h00, 1'b0);

        // len=0 with reset after the third write.
        @(negedge clk);
        rif.req_op = 1'b0; rif.req_block = 4'd5; rif.req_prefix = 4'h9;
        rif.req_len = 3'd0; rif.req_nexthop = 8'hC3; rif.req_valid = 1'b1;
        w0 = wr_count;
        @(posedge clk);
        @(negedge clk);
        rif.req_valid = 1'b0;
        k = 0;
        while (wr_count - w0 < 3 && k < 40) begin @(negedge clk); k++; end
        chk("abort_reached_3", 32'(wr_count - w0), 32'd3);
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(rif.req_ready), 32'd1);
        chk("abort_wr_en", 32'(ram_wr_en), 32'd0);
        chk("abort_done", 32'(rif.done), 32'd0);
        chk("abort_err", 32'(rif.err), 32'd0);
        chk("abort_rd_addr", 32'(ram_rd_addr), 32'd0);
        chk("abort_wr_addr", 32'(ram_wr_addr), 32'd0);
        chk("abort_wr_data", 32'(ram_wr_data), 32'd0);
        for (int s = 0; s < 3; s++) ref_mem[80 + s] = {1'b1, 8'hC3, ref_mem[80 + s][6:0]};
        repeat (3) @(negedge clk);
        chk("abort_write_total", 32'(wr_count - w0), 32'd3);
        rst = 1'b1;
        check_block("abort_block", 4'd5);
        do_req(1'b1, 4'd5, 4'h2, 3'd0, 8'h00, 7'h3C, 1'b0);

        // Randomized requests against the reference model.
        for (int r = 0; r < 30; r++) begin
            do_req(1'($urandom), 4'($urandom), 4'($urandom), 3'($urandom_range(0, 5)),
                   8'($urandom), 7'($urandom), 1'($urandom));
        end

        n = 0; e = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
